alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_div.sv | 38 +++
 rtl/alu_unit.sv | 104 ++++++++++
 tb/tb_alu_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU slice: default data width and one-hot opcodes.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

endpackage

// File: rtl/alu_div.sv
// Combinational unsigned divider: WIDTH-stage restoring array, one quotient bit per stage.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH:0]   trial;

  // Each iteration is one array row: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    q_raw   = '0;
    rem_acc = '0;
    trial   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      trial = {rem_acc, dividend[i]};
      if (trial >= {1'b0, divisor}) begin
        trial    = trial - {1'b0, divisor};
        q_raw[i] = 1'b1;
      end
      rem_acc = trial[WIDTH-1:0];
    end
  end

  // A zero divisor makes every row "fit", so the raw array would give all ones.
  assign div_by_zero = (divisor == '0);
  assign quotient    = div_by_zero ? '0 : q_raw;
  assign remainder   = div_by_zero ? dividend : rem_acc;

endmodule

// File: rtl/alu_unit.sv
// Single-cycle-latency ALU: add/sub/mul/div on unsigned operands with a registered result and flags.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             carry,
  output logic             mul_ovf,
  output logic             div_by_zero,
  output logic             op_err
);

  logic [WIDTH:0]     sum_full;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_rem_unused;
  logic               div_dbz;

  logic [WIDTH-1:0]   y_p0;
  logic               carry_p0, mul_ovf_p0, dbz_p0, op_err_p0;

  logic [WIDTH-1:0]   y_p1;
  logic               carry_p1, mul_ovf_p1, dbz_p1, op_err_p1, vld_p1;

  assign sum_full = {1'b0, A} + {1'b0, B};
  assign diff     = A - B;
  assign prod     = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  alu_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .dividend   (A),
    .divisor    (B),
    .quotient   (div_q),
    .remainder  (div_rem_unused),
    .div_by_zero(div_dbz)
  );

  // Stage p0: opcode decode and result select; anything not exactly one legal bit is an error.
  always_comb begin
    y_p0       = '0;
    carry_p0   = 1'b0;
    mul_ovf_p0 = 1'b0;
    dbz_p0     = 1'b0;
    op_err_p0  = 1'b0;
    case (op)
      OP_ADD: begin
        y_p0     = sum_full[WIDTH-1:0];
        carry_p0 = sum_full[WIDTH];
      end
      OP_SUB: begin
        y_p0     = diff;
        carry_p0 = (A < B);
      end
      OP_MUL: begin
        y_p0       = prod[WIDTH-1:0];
        mul_ovf_p0 = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        y_p0   = div_q;
        dbz_p0 = div_dbz;
      end
      default: op_err_p0 = 1'b1;
    endcase
  end

  // Stage p1: output register; results hold while no new sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      y_p1       <= '0;
      carry_p1   <= 1'b0;
      mul_ovf_p1 <= 1'b0;
      dbz_p1     <= 1'b0;
      op_err_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        y_p1       <= y_p0;
        carry_p1   <= carry_p0;
        mul_ovf_p1 <= mul_ovf_p0;
        dbz_p1     <= dbz_p0;
        op_err_p1  <= op_err_p0;
      end
    end
  end

  assign Y           = y_p1;
  assign out_valid   = vld_p1;
  assign carry       = carry_p1;
  assign mul_ovf     = mul_ovf_p1;
  assign div_by_zero = dbz_p1;
  assign op_err      = op_err_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and sweep bench for alu_unit with immediate-assertion checks.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  op;
  logic        in_valid;
  logic [31:0] Y;
  logic        out_valid;
  logic        carry;
  logic        mul_ovf;
  logic        div_by_zero;
  logic        op_err;

  int total;
  int bad;

  alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .op         (op),
    .in_valid   (in_valid),
    .Y          (Y),
    .out_valid  (out_valid),
    .carry      (carry),
    .mul_ovf    (mul_ovf),
    .div_by_zero(div_by_zero),
    .op_err     (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input set at the falling edge, then step to 1 ns past the next rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] o, input logic v, input logic r);
    @(negedge clk);
    A        = a;
    B        = b;
    op       = o;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {out_valid, carry, mul_ovf, div_by_zero, op_err}.
  task automatic chk(input string tag, input logic [31:0] ey, input logic [4:0] ef);
    logic [4:0] gf;
    gf = {out_valid, carry, mul_ovf, div_by_zero, op_err};
    total++;
    assert ({Y, gf} === {ey, ef})
    else begin
      bad++;
      $error("FAIL %s: observed Y=%h flags=%b expected Y=%h flags=%b", tag, Y, gf, ey, ef);
    end
  endtask

  // Reference model: returns {Y, carry, mul_ovf, div_by_zero, op_err}.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] o);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] y;
    logic        c, m, z, e;
    y = '0; c = 1'b0; m = 1'b0; z = 1'b0; e = 1'b0;
    case (o)
      4'b0001: begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32]; end
      4'b0010: begin y = a - b; c = (a < b); end
      4'b0100: begin p = {32'd0, a} * {32'd0, b}; y = p[31:0]; m = (p[63:32] != 32'd0); end
      4'b1000: begin
        if (b == 32'd0) z = 1'b1;
        else y = a / b;
      end
      default: e = 1'b1;
    endcase
    return {y, c, m, z, e};
  endfunction

  initial begin
    logic [35:0] exp_v;
    logic [3:0]  sweep_ops [4];
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = 4'b0001;
    sweep_ops[0] = 4'b0001; sweep_ops[1] = 4'b0010;
    sweep_ops[2] = 4'b0100; sweep_ops[3] = 4'b1000;

    // Reset with a sample offered: sample is dropped.
    drive(32'h0000_FFFF, 32'h0000_FFFF, 4'b0001, 1'b1, 1'b1);
    chk("reset_state", 32'h0, 5'b00000);

    // First cycle after reset is accepted normally.
    drive(32'h0000_FFFF, 32'h0000_FFFF, 4'b0001, 1'b1, 1'b0);
    chk("add_ffff", 32'h0001_FFFE, 5'b10000);
    drive(32'h0000_0000, 32'h0000_FFFF, 4'b0010, 1'b1, 1'b0);
    chk("sub_borrow", 32'hFFFF_0001, 5'b11000);
    drive(32'h0000_0005, 32'h0000_0003, 4'b0010, 1'b1, 1'b0);
    chk("sub_plain", 32'h0000_0002, 5'b10000);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 1'b1, 1'b0);
    chk("add_carry", 32'h0, 5'b11000);
    drive(32'h0000_FFFF, 32'h0000_FFFF, 4'b0100, 1'b1, 1'b0);
    chk("mul_fit", 32'hFFFE_0001, 5'b10000);
    drive(32'h0001_0000, 32'h0001_0000, 4'b0100, 1'b1, 1'b0);
    chk("mul_ovf", 32'h0, 5'b10100);
    drive(32'h0000_FFFF, 32'h0000_0000, 4'b1000, 1'b1, 1'b0);
    chk("div_zero", 32'h0, 5'b10010);
    drive(32'h0000_1000, 32'h0000_0007, 4'b1000, 1'b1, 1'b0);
    chk("div_4096_7", 32'h0000_0249, 5'b10000);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 4'b1000, 1'b1, 1'b0);
    chk("div_by_one", 32'hFFFF_FFFF, 5'b10000);
    drive(32'h1234_5678, 32'h0000_0001, 4'b0011, 1'b1, 1'b0);
    chk("op_two_bits", 32'h0, 5'b10001);
    drive(32'h1234_5678, 32'h0000_0001, 4'b0000, 1'b1, 1'b0);
    chk("op_zero", 32'h0, 5'b10001);

    // Idle cycles hold the last result and drop out_valid.
    drive(32'h0000_0007, 32'h0000_0002, 4'b0001, 1'b1, 1'b0);
    chk("add_before_idle", 32'h0000_0009, 5'b10000);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b0);
    chk("idle_hold", 32'h0000_0009, 5'b00000);
    drive(32'h0001_0000, 32'h0001_0000, 4'b0100, 1'b0, 1'b0);
    chk("idle_hold2", 32'h0000_0009, 5'b00000);

    // Mid-run reset clears result and discards the offered sample.
    drive(32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 1'b1, 1'b1);
    chk("reset_midrun", 32'h0, 5'b00000);
    drive(32'h0000_0064, 32'h0000_000A, 4'b1000, 1'b1, 1'b0);
    chk("after_reset", 32'h0000_000A, 5'b10000);

    // Back-to-back sweep over 0..999 per op, with periodic zero divisors.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] a_v, b_v;
        a_v = 32'(i);
        b_v = (i % 100 == 0) ? 32'd0 : 32'((i * 37 + 11) % 1000);
        drive(a_v, b_v, sweep_ops[k], 1'b1, 1'b0);
        exp_v = ref_model(a_v, b_v, sweep_ops[k]);
        chk("sweep", exp_v[35:4], {1'b1, exp_v[3:0]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
